gru_mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port weight/state memory (1-cycle synchronous read, read suppressed on write cycles).
- Lets the GRU gate datapath (requester 0) and the load/host path (requester 1) share one memory.
- Valid/ready request handshake, registered memory command, bounded-burst round-robin fairness, and routing of read data back to the issuer.

---
 rtl/gru_mem_arbiter.sv | 103 ++++++++++
 tb/tb_gru_mem_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gru_mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous memory.
// Bounded-burst round-robin grant, registered memory command, read data routed back to the issuer.
module gru_mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_MAX  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_data_in,
  output logic                    mem_we,
  input  logic [DATA_WIDTH-1:0]   mem_data_out
);
  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);

  logic                  owner;
  logic [CW-1:0]         burst_cnt;
  logic [1:0]            grant;
  logic                  gid;
  logic                  xfer;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [1:0]            vld_pipe;
  logic [1:0]            id_pipe;

  // Owner keeps the port while under its burst budget; the waiting side takes over once it is spent.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (burst_cnt < BMAX) grant = owner ? 2'b10 : 2'b01;
        else                  grant = owner ? 2'b01 : 2'b10;
      end
      default: grant = 2'b00;
    endcase
    if (!rst_n) grant = 2'b00;
  end

  assign req_ready = grant;
  assign xfer      = |grant;
  assign gid       = grant[1];
  assign sel_we    = req_we[gid];
  assign sel_addr  = req_addr[gid*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = req_wdata[gid*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= 1'b0;
      burst_cnt <= '0;
    end else if (xfer) begin
      if (gid == owner) begin
        if (burst_cnt != BMAX) burst_cnt <= burst_cnt + CW'(1);
      end else begin
        owner     <= gid;
        burst_cnt <= CW'(1);
      end
    end else begin
      burst_cnt <= '0;
    end
  end

  // Idle cycles leave addr/data parked; mem_we=0 makes them harmless reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
    end else if (xfer) begin
      mem_we      <= sel_we;
      mem_addr    <= sel_addr;
      mem_data_in <= sel_wdata;
    end else begin
      mem_we      <= 1'b0;
    end
  end

  // Stage 0: read issued to memory; stage 1: memory data present on mem_data_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], xfer & ~sel_we};
      id_pipe  <= {id_pipe[0], gid};
    end
  end

  assign rsp_valid = {vld_pipe[1] & id_pipe[1], vld_pipe[1] & ~id_pipe[1]};
  assign rsp_rdata = mem_data_out;

endmodule

// File: tb/tb_gru_mem_arbiter.sv
// Directed bench for gru_mem_arbiter: behavioural memory, response scoreboard, grant checks.
// A second instance with BURST_MAX=1 checks strict alternation.
module tb_gru_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata, mem_data_in, mem_data_out;
  logic [AW-1:0] mem_addr;
  logic          mem_we;

  logic [1:0]    b_valid, b_ready, b_rsp_valid;
  logic [DW-1:0] b_rsp_rdata, b_mem_data_in;
  logic [AW-1:0] b_mem_addr;
  logic          b_mem_we;
  logic [1:0]    b_zero2 = 2'b00;
  logic [2*AW-1:0] b_zero_addr = '0;
  logic [2*DW-1:0] b_zero_data = '0;
  logic [DW-1:0] b_mem_out = '0;

  typedef struct { logic id; logic [DW-1:0] data; } rsp_t;
  rsp_t exp_q[$];
  int compared = 0;
  int failed = 0;

  always #5 clk = ~clk;

  gru_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_we(mem_we), .mem_data_out(mem_data_out));

  gru_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_MAX(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_we(b_zero2),
    .req_addr(b_zero_addr), .req_wdata(b_zero_data), .req_ready(b_ready),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .mem_addr(b_mem_addr),
    .mem_data_in(b_mem_data_in), .mem_we(b_mem_we), .mem_data_out(b_mem_out));

  // Single-port memory: 1-cycle synchronous read, no read on write cycles.
  logic [DW-1:0] mem [256];
  logic preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + i;
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h11] <= 32'h0BADF00D;
      preloaded  <= 1'b1;
    end else if (mem_we) mem[mem_addr] <= mem_data_in;
    else mem_data_out <= mem[mem_addr];
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic id, logic [DW-1:0] d);
    rsp_t r;
    r.id = id;
    r.data = d;
    exp_q.push_back(r);
  endtask

  // Monitor: every presented response must match the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid !== 2'b00) begin
      rsp_t r;
      compared++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL rsp_unexpected: rsp_valid=%b data=%h, none expected", rsp_valid, rsp_rdata);
      end else begin
        r = exp_q.pop_front();
        if (rsp_valid !== (r.id ? 2'b10 : 2'b01) || rsp_rdata !== r.data) begin
          failed++;
          $display("FAIL rsp_data: rsp_valid=%b data=%h expected id=%0d data=%h",
                   rsp_valid, rsp_rdata, r.id, r.data);
        end
      end
    end
  end

  logic [1:0] exp4 [12] = '{2'b01,2'b01,2'b01,2'b01,2'b10,2'b10,2'b10,2'b10,2'b01,2'b01,2'b01,2'b01};

  initial begin
    rst_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; b_valid = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready_idle", {62'd0, req_ready}, 64'd0);
    chk("reset_mem_addr", {56'd0, mem_addr}, 64'd0);
    tick();

    // Mid-stream reset with a read in flight: it must be dropped.
    req_valid = 2'b11;
    req_addr  = {8'h11, 8'h10};
    @(negedge clk);
    chk("pre_reset_grant", {62'd0, req_ready}, 64'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
    chk("rst_mem_addr", {56'd0, mem_addr}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    b_valid = 2'b11;

    // Contention: 4-bursts on dut, strict alternation on dut1.
    for (int k = 0; k < 12; k++) begin
      if (exp4[k] == 2'b10) push(1'b1, 32'h0BADF00D);
      else                  push(1'b0, 32'hDEADBEEF);
      @(negedge clk);
      chk($sformatf("contend4_%0d", k), {62'd0, req_ready}, {62'd0, exp4[k]});
      chk($sformatf("contend1_%0d", k), {62'd0, b_ready}, (k % 2 == 0) ? 64'd1 : 64'd2);
      tick();
    end
    req_valid = 2'b00;
    b_valid   = 2'b00;

    // Idle gap clears the saturated burst count so owner 0 wins again.
    req_valid = 2'b01;
    push(1'b0, 32'hDEADBEEF);
    @(negedge clk);
    chk("gap_single", {62'd0, req_ready}, 64'd1);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("gap_idle", {62'd0, req_ready}, 64'd0);
    tick();
    req_valid = 2'b11;
    push(1'b0, 32'hDEADBEEF);
    @(negedge clk);
    chk("gap_owner0", {62'd0, req_ready}, 64'd1);
    tick();
    req_valid = 2'b00;
    repeat (3) tick();

    // Single read of 0x10.
    req_valid = 2'b01;
    req_addr  = {8'h00, 8'h10};
    push(1'b0, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_ready", {62'd0, req_ready}, 64'd1);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("single_mem_addr", {56'd0, mem_addr}, 64'h10);
    chk("single_mem_we", {63'd0, mem_we}, 64'd0);
    tick();
    repeat (2) tick();

    // Back-to-back reads of 0..9 from requester 0.
    for (int i = 0; i < 10; i++) begin
      req_valid = 2'b01;
      req_addr  = {8'h00, 8'(i)};
      push(1'b0, 32'hA000_0000 + i);
      @(negedge clk);
      chk($sformatf("b2b_ready_%0d", i), {62'd0, req_ready}, 64'd1);
      tick();
    end
    req_valid = 2'b00;
    repeat (3) tick();

    // Requester 1: write 0x05 then read it back on the next cycle.
    req_valid = 2'b10;
    req_we    = 2'b10;
    req_addr  = {8'h05, 8'h00};
    req_wdata = {32'h12345678, 32'h0};
    @(negedge clk);
    chk("wr_ready", {62'd0, req_ready}, 64'd2);
    tick();
    req_we = 2'b00;
    push(1'b1, 32'h12345678);
    @(negedge clk);
    chk("rd_ready", {62'd0, req_ready}, 64'd2);
    chk("wr_mem_we", {63'd0, mem_we}, 64'd1);
    chk("wr_mem_addr", {56'd0, mem_addr}, 64'h05);
    chk("wr_mem_data", {32'd0, mem_data_in}, 64'h12345678);
    tick();
    req_valid = 2'b00;

    repeat (6) tick();
    chk("rsp_missing", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
